pipe_reg_chain: RTL and testbench

Parametrised elastic register pipeline: WIDTH-bit data through DEPTH stages with a valid/ready handshake on both sides. It succeeds the single-stage `test_module_1` register. It adds configurable depth, backpressure with bubble collapsing, and a synchronous flush. It sits between any producer/consumer pair in the design that needs registered retiming with flow control.

---
 rtl/pipe_reg_chain.sv | 76 +++++++
 tb/tb_pipe_reg_chain.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: elastic valid/ready register pipeline with bubble collapsing and flush.
// Define PIPE_REG_CHAIN_COUNT_EN to add the o_count occupancy output.
module pipe_reg_chain #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
`ifdef PIPE_REG_CHAIN_COUNT_EN
    ,
    localparam int CW = $clog2(DEPTH + 1)
`endif
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
`ifdef PIPE_REG_CHAIN_COUNT_EN
    ,
    output logic [CW-1:0]    o_count
`endif
);
    logic [DEPTH-1:0] v_q, v_d, en;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];
    logic             run;

    // A stage may advance if any stage at or beyond it is empty, or the output drains.
    always_comb begin
        run = i_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            run   = run || !v_q[k];
            en[k] = run;
        end
    end

    assign o_ready = en[0] && !i_flush;

    always_comb begin
        v_d = v_q;
        for (int k = 0; k < DEPTH; k++) d_d[k] = d_q[k];
        if (en[0]) begin
            v_d[0] = i_valid && o_ready;
            d_d[0] = i_data;
        end
        for (int k = 1; k < DEPTH; k++) begin
            if (en[k]) begin
                v_d[k] = v_q[k-1];
                d_d[k] = d_q[k-1];
            end
        end
        if (i_flush) v_d = '0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            v_q <= '0;
            for (int k = 0; k < DEPTH; k++) d_q[k] <= '0;
        end else begin
            v_q <= v_d;
            for (int k = 0; k < DEPTH; k++) d_q[k] <= d_d[k];
        end
    end

    assign o_valid = v_q[DEPTH-1];
    assign o_data  = d_q[DEPTH-1];

`ifdef PIPE_REG_CHAIN_COUNT_EN
    always_comb begin
        o_count = '0;
        for (int k = 0; k < DEPTH; k++) o_count = o_count + CW'(v_q[k]);
    end
`endif
endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain: randomized and directed bench for pipe_reg_chain against a word-position model.
module tb_pipe_reg_chain;
    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst, flush, valid, ready;
    logic [W-1:0] i_data;
    logic         o_ready, o_valid;
    logic [W-1:0] o_data;
`ifdef PIPE_REG_CHAIN_COUNT_EN
    logic [$clog2(D+1)-1:0] o_count;
`endif

    pipe_reg_chain #(.WIDTH(W), .DEPTH(D)) dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(o_ready),
        .i_data(i_data), .o_valid(o_valid), .i_ready(ready), .o_data(o_data)
`ifdef PIPE_REG_CHAIN_COUNT_EN
        , .o_count(o_count)
`endif
    );

    always #5 clk = ~clk;

    // Model: words in flight (oldest first) with their stage positions.
    logic [W-1:0] mq[$];
    int           mp[$];
    logic [W-1:0] offer[$];
    int           n_chk = 0;
    int           n_err = 0;
    logic         last_acc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [W-1:0] d, input logic r, input logic f);
        logic ev, er, ox;
        int   np;
        valid = v; i_data = d; ready = r; flush = f;
        @(negedge clk);
        ev = mq.size() > 0 && mp[0] == D - 1;
        er = !f && (mq.size() < D || r);
        chk("o_valid", 32'(o_valid), 32'(ev));
        if (ev) chk("o_data", 32'(o_data), 32'(mq[0]));
        chk("o_ready", 32'(o_ready), 32'(er));
`ifdef PIPE_REG_CHAIN_COUNT_EN
        chk("o_count", 32'(o_count), 32'(mq.size()));
`endif
        @(posedge clk);
        ox = ev && r;
        last_acc = v && er;
        if (ox) begin
            void'(mq.pop_front());
            void'(mp.pop_front());
        end
        for (int i = 0; i < mp.size(); i++) begin
            np = (i == 0) ? D - 1 : mp[i-1] - 1;
            mp[i] = (mp[i] + 1 < np) ? mp[i] + 1 : np;
        end
        if (f) begin
            mq.delete();
            mp.delete();
        end else if (last_acc) begin
            mq.push_back(d);
            mp.push_back(0);
        end
        #1;
    endtask

    task automatic feed(input logic r, input int max);
        for (int c = 0; c < max && offer.size() > 0; c++) begin
            cyc(1'b1, offer[0], r, 1'b0);
            if (last_acc) void'(offer.pop_front());
        end
    endtask

    task automatic idle(input logic r, input int n);
        for (int c = 0; c < n; c++) cyc(1'b0, '0, r, 1'b0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; valid = 1'b0; ready = 1'b1; i_data = '0;
        #3;
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_o_data", 32'(o_data), 32'd0);
        chk("rst_o_ready", 32'(o_ready), 32'd1);
`ifdef PIPE_REG_CHAIN_COUNT_EN
        chk("rst_o_count", 32'(o_count), 32'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        idle(1'b1, 10);

        for (int w = 1; w <= 16; w++) offer.push_back(W'(w));
        feed(1'b1, 100);
        idle(1'b1, 6);

        for (int w = 'hA0; w <= 'hA5; w++) offer.push_back(W'(w));
        feed(1'b0, 8);
        chk("bp_left", 32'(offer.size()), 32'd2);
        feed(1'b1, 50);
        idle(1'b1, 6);

        cyc(1'b1, 8'h11, 1'b0, 1'b0);
        idle(1'b0, 2);
        cyc(1'b1, 8'h22, 1'b0, 1'b0);
        idle(1'b0, 4);
        idle(1'b1, 4);

        for (int w = 'h30; w <= 'h33; w++) offer.push_back(W'(w));
        feed(1'b0, 10);
        cyc(1'b1, 8'h99, 1'b0, 1'b1);
        idle(1'b1, 6);

        repeat (400)
            cyc(1'($urandom_range(0, 1)), W'($urandom), $urandom_range(0, 3) != 0,
                $urandom_range(0, 31) == 0);
        idle(1'b1, 6);

        cyc(1'b1, 8'h41, 1'b0, 1'b0);
        cyc(1'b1, 8'h42, 1'b0, 1'b0);
        cyc(1'b1, 8'h43, 1'b0, 1'b0);
        idle(1'b0, 2);
        rst = 1'b1;
        #1;
        chk("arst_o_valid", 32'(o_valid), 32'd0);
        chk("arst_o_data", 32'(o_data), 32'd0);
        chk("arst_o_ready", 32'(o_ready), 32'd1);
        mq.delete();
        mp.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        idle(1'b1, 4);
        offer.push_back(8'h55);
        offer.push_back(8'h66);
        feed(1'b1, 10);
        idle(1'b1, 6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
